// File: rtl/aib_axi_follower_sram_slave.sv
// AXI4 slave terminating the AIB follower bridge, serving bursts from a 128-bit SRAM.
// Optional out-of-range checking is enabled by defining AIB_AXI_SRAM_RANGE_CHECK_EN.
module aib_axi_follower_sram_slave #(
  parameter int unsigned ADDRWIDTH  = 32,
  parameter int unsigned IDWIDTH    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic [IDWIDTH-1:0]   s_axi_awid,
  input  logic [ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic [2:0]           s_axi_awsize,
  input  logic [1:0]           s_axi_awburst,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [IDWIDTH-1:0]   s_axi_wid,
  input  logic [127:0]         s_axi_wdata,
  input  logic [15:0]          s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [IDWIDTH-1:0]   s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [IDWIDTH-1:0]   s_axi_arid,
  input  logic [ADDRWIDTH-1:0] s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic [2:0]           s_axi_arsize,
  input  logic [1:0]           s_axi_arburst,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [IDWIDTH-1:0]   s_axi_rid,
  output logic [127:0]         s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready
);

  localparam int unsigned STRBW    = 16;
  localparam int unsigned WORD_LSB = 4;
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned OOR_LSB  = DEPTH_LOG2 + WORD_LSB;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // AXI next-beat address; reserved burst encoding behaves as INCR
  function automatic logic [ADDRWIDTH-1:0] next_addr(
    input logic [ADDRWIDTH-1:0] addr,
    input logic [7:0]           len,
    input logic [2:0]           size,
    input logic [1:0]           burst
  );
    logic [ADDRWIDTH-1:0] incr;
    logic [ADDRWIDTH-1:0] wmask;
    logic [ADDRWIDTH-1:0] res;
    incr  = ADDRWIDTH'(1) << size;
    wmask = ((ADDRWIDTH'(len) + ADDRWIDTH'(1)) << size) - ADDRWIDTH'(1);
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~wmask) | ((addr + incr) & wmask);
      default: res = addr + incr;
    endcase
    return res;
  endfunction

  logic [127:0] r_mem [DEPTH];

  wstate_t              r_wstate;
  wstate_t              w_wstate_nxt;
  logic [IDWIDTH-1:0]   r_awid;
  logic [ADDRWIDTH-1:0] r_awaddr;
  logic [7:0]           r_awlen;
  logic [2:0]           r_awsize;
  logic [1:0]           r_awburst;
  logic [7:0]           r_wbeat;
  logic                 r_werr;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_wbeat_last;
  logic                 w_wr_oor;
  logic                 w_mem_we;
  logic [ADDRWIDTH-1:0] w_aw_next;
  logic [DEPTH_LOG2-1:0] w_wr_idx;

  rstate_t              r_rstate;
  rstate_t              w_rstate_nxt;
  logic [IDWIDTH-1:0]   r_rid;
  logic [ADDRWIDTH-1:0] r_araddr;
  logic [7:0]           r_arlen;
  logic [2:0]           r_arsize;
  logic [1:0]           r_arburst;
  logic [7:0]           r_rbeat;
  logic [127:0]         r_rdata;
  logic [1:0]           r_rresp;
  logic                 r_rlast;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_rd_load;
  logic                 w_rd_oor;
  logic [1:0]           w_rd_burst;
  logic [ADDRWIDTH-1:0] w_ar_next;
  logic [DEPTH_LOG2-1:0] w_rd_idx;

  logic                 w_unused_wid;
  assign w_unused_wid = ^s_axi_wid;

  // ---------------- write channel ----------------
  assign w_aw_hs      = (r_wstate == W_IDLE) && s_axi_awvalid;
  assign w_w_hs       = (r_wstate == W_DATA) && s_axi_wvalid;
  assign w_wbeat_last = (r_wbeat == r_awlen);
  assign w_aw_next    = next_addr(r_awaddr, r_awlen, r_awsize, r_awburst);
  assign w_wr_idx     = r_awaddr[OOR_LSB-1:WORD_LSB];
  assign w_mem_we     = w_w_hs && !w_wr_oor && !rst_wr;

`ifdef AIB_AXI_SRAM_RANGE_CHECK_EN
  assign w_wr_oor = |(r_awaddr >> OOR_LSB);
`else
  assign w_wr_oor = 1'b0;
`endif

  always_ff @(posedge clk_wr) begin
    if (rst_wr) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (s_axi_awvalid) w_wstate_nxt = W_DATA;
      W_DATA:  if (s_axi_wvalid && (s_axi_wlast || w_wbeat_last)) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE:  s_axi_awready = 1'b1;
      W_DATA:  s_axi_wready  = 1'b1;
      W_RESP:  s_axi_bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_bid   = r_awid;
  assign s_axi_bresp = r_werr ? 2'b10 : 2'b00;

  // Burst context; a wlast/awlen disagreement on the exit beat flags SLVERR
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid    <= s_axi_awid;
      r_awaddr  <= s_axi_awaddr;
      r_awlen   <= s_axi_awlen;
      r_awsize  <= s_axi_awsize;
      r_awburst <= s_axi_awburst;
      r_wbeat   <= '0;
      r_werr    <= (s_axi_awburst == 2'b11);
    end else if (w_w_hs) begin
      r_wbeat   <= r_wbeat + 8'd1;
      r_awaddr  <= w_aw_next;
      r_werr    <= r_werr | w_wr_oor | (s_axi_wlast ^ w_wbeat_last);
    end
  end

  // Byte-enabled array write; contents deliberately survive reset
  always_ff @(posedge clk_wr) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRBW; b++) begin
        if (s_axi_wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  assign w_ar_hs    = (r_rstate == R_IDLE) && s_axi_arvalid;
  assign w_r_hs     = (r_rstate == R_DATA) && s_axi_rready;
  assign w_ar_next  = next_addr(r_araddr, r_arlen, r_arsize, r_arburst);
  assign w_rd_load  = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rd_burst = (r_rstate == R_IDLE) ? s_axi_arburst : r_arburst;
  assign w_rd_idx   = (r_rstate == R_IDLE) ? s_axi_araddr[OOR_LSB-1:WORD_LSB]
                                           : w_ar_next[OOR_LSB-1:WORD_LSB];

`ifdef AIB_AXI_SRAM_RANGE_CHECK_EN
  assign w_rd_oor = (r_rstate == R_IDLE) ? |(s_axi_araddr >> OOR_LSB) : |(w_ar_next >> OOR_LSB);
`else
  assign w_rd_oor = 1'b0;
`endif

  always_ff @(posedge clk_wr) begin
    if (rst_wr) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi_arvalid) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE:  s_axi_arready = 1'b1;
      R_DATA:  s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_rid   = r_rid;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign s_axi_rlast = r_rlast;

  // Next beat is fetched on the accepting edge so rdata is ready one cycle later
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_rid     <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rbeat   <= '0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      if (w_ar_hs) begin
        r_rid     <= s_axi_arid;
        r_araddr  <= s_axi_araddr;
        r_arlen   <= s_axi_arlen;
        r_arsize  <= s_axi_arsize;
        r_arburst <= s_axi_arburst;
        r_rbeat   <= '0;
        r_rlast   <= (s_axi_arlen == 8'd0);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_araddr <= w_ar_next;
          r_rbeat  <= r_rbeat + 8'd1;
          r_rlast  <= ((r_rbeat + 8'd1) == r_arlen);
        end
      end
      if (w_rd_load) begin
        r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_idx];
        r_rresp <= (w_rd_oor || (w_rd_burst == 2'b11)) ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_aib_axi_follower_sram_slave.sv
// Bench for aib_axi_follower_sram_slave: vector table of bursts checked against a
// byte-level memory model through R/B scoreboards, plus wrap and reset sequences.
module tb_aib_axi_follower_sram_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned DL = 10;
`ifdef AIB_AXI_SRAM_RANGE_CHECK_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_wr;
  logic [IW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [127:0]  wdata, rdata;
  logic [15:0]   wstrb;

  always #5 clk = ~clk;

  aib_axi_follower_sram_slave #(.ADDRWIDTH(AW), .IDWIDTH(IW), .DEPTH_LOG2(DL)) dut (
    .clk_wr(clk), .rst_wr(rst_wr),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct {
    bit           wr;
    logic [3:0]   id;
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic [15:0]  strb;
    logic [127:0] d0;
    int           wl;     // beat carrying wlast (beyond len means never)
    logic [1:0]   resp;
    bit           stall;
  } vec_t;

  typedef struct { logic [3:0] id; logic [127:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t        rq[$];
  bexp_t        bq[$];
  logic [127:0] mdl [int];
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc, wb;
    inc = 32'd1 << size;
    wb  = (32'(len) + 32'd1) << size;
    if (burst == 2'b00)      return a;
    else if (burst == 2'b10) return (a & ~(wb - 32'd1)) | ((a + inc) & (wb - 32'd1));
    else                     return a + inc;
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef AIB_AXI_SRAM_RANGE_CHECK_EN
    return (a >> (DL + 4)) != 32'd0;
`else
    return (a == 32'hFFFF_FFFF);  // never true for the addresses used here
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL+3:4]);
  endfunction

  function automatic void mwrite(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    logic [127:0] w;
    int k;
    k = widx(a);
    w = mdl.exists(k) ? mdl[k] : 128'd0;
    for (int b = 0; b < 16; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mdl[k] = w;
  endfunction

  task automatic do_write(input vec_t v);
    int          nb;
    bit          ok;
    logic [31:0] a;
    bexp_t       be;
    @(negedge clk);
    awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (awready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout("aw_handshake"); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready_latency", wready, 1'b1);
    bq.push_back('{v.id, v.resp});
    nb = ((v.wl < int'(v.len)) ? v.wl : int'(v.len)) + 1;
    a  = v.addr;
    for (int b = 0; b < nb; b++) begin
      wvalid = 1'b1; wdata = v.d0 + 128'(b); wstrb = v.strb; wlast = (b == v.wl);
      chk("wready_beat", wready, 1'b1);
      if (!oor(a)) mwrite(a, wdata, wstrb);
      a = nxt(a, v.len, v.size, v.burst);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_latency", bvalid, 1'b1);
    bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout("b_wait"); bready = 1'b0; return; end
    be = bq.pop_front();
    chk("bid", bid, be.id);
    chk("bresp", bresp, be.resp);
    @(negedge clk);
    bready = 1'b0;
    chk("awready_after_b", awready, 1'b1);
  endtask

  function automatic void push_model_read(input vec_t v);
    logic [31:0] a;
    a = v.addr;
    for (int b = 0; b <= int'(v.len); b++) begin
      rq.push_back('{v.id, oor(a) ? 128'd0 : (mdl.exists(widx(a)) ? mdl[widx(a)] : 128'd0),
                     v.resp, (b == int'(v.len))});
      a = nxt(a, v.len, v.size, v.burst);
    end
  endfunction

  task automatic issue_read(input vec_t v);
    bit ok;
    @(negedge clk);
    arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1'b1);
  endtask

  // Drains the R channel at the current negedge; stall pattern deasserts rready every third cycle
  task automatic collect(input bit stall);
    bit    done;
    rexp_t e;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      rready = stall ? (cyc % 3 != 1) : 1'b1;
      if (rvalid) begin
        if (rq.size() == 0) begin
          chk("r_unexpected_beat", rvalid, 1'b0);
        end else begin
          e = rq[0];
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
          chk("rlast", rlast, e.last);
          chk("rid", rid, e.id);
          if (rready) begin
            void'(rq.pop_front());
            done = e.last;
          end
        end
      end
      @(negedge clk);
    end
    rready = 1'b0;
    if (!done) timeout("r_burst");
    chk("rvalid_after_last", rvalid, 1'b0);
    chk("arready_after_last", arready, 1'b1);
    chk("r_queue_empty", 128'(rq.size()), 128'd0);
    rq.delete();
  endtask

  vec_t vt [0:15];
  vec_t hv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_wr = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    //       wr    id     addr           len   sz    burst  strb      d0                                        wl   resp      stall
    vt[0]  = '{1'b1, 4'h5, 32'h0000_0100, 8'd3, 3'd4, 2'b01, 16'hFFFF, 128'hA0,                                  3,   2'b00,    1'b0};
    vt[1]  = '{1'b0, 4'h6, 32'h0000_0100, 8'd3, 3'd4, 2'b01, 16'h0,    128'h0,                                   0,   2'b00,    1'b0};
    vt[2]  = '{1'b1, 4'h1, 32'h0000_0040, 8'd0, 3'd4, 2'b01, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 2'b00, 1'b0};
    vt[3]  = '{1'b1, 4'h2, 32'h0000_0040, 8'd0, 3'd4, 2'b01, 16'h000F, {128{1'b1}},                              0,   2'b00,    1'b0};
    vt[4]  = '{1'b0, 4'h3, 32'h0000_0040, 8'd0, 3'd4, 2'b01, 16'h0,    128'h0,                                   0,   2'b00,    1'b0};
    vt[5]  = '{1'b1, 4'h4, 32'h0000_0300, 8'd3, 3'd4, 2'b01, 16'hFFFF, 128'hB0,                                  3,   2'b00,    1'b0};
    vt[6]  = '{1'b1, 4'h7, 32'h0000_0300, 8'd3, 3'd4, 2'b01, 16'hFFFF, 128'hC0,                                  1,   2'b10,    1'b0};
    vt[7]  = '{1'b0, 4'h8, 32'h0000_0300, 8'd3, 3'd4, 2'b01, 16'h0,    128'h0,                                   0,   2'b00,    1'b0};
    vt[8]  = '{1'b1, 4'h9, 32'h0000_0380, 8'd1, 3'd4, 2'b01, 16'hFFFF, 128'hD0,                                  255, 2'b10,    1'b0};
    vt[9]  = '{1'b1, 4'hA, 32'h0000_0500, 8'd1, 3'd4, 2'b11, 16'hFFFF, 128'hE0,                                  1,   2'b10,    1'b0};
    vt[10] = '{1'b0, 4'hB, 32'h0000_0500, 8'd1, 3'd4, 2'b11, 16'h0,    128'h0,                                   0,   2'b10,    1'b0};
    vt[11] = '{1'b1, 4'hC, 32'h0000_0600, 8'd1, 3'd4, 2'b00, 16'hFFFF, 128'hF0,                                  1,   2'b00,    1'b0};
    vt[12] = '{1'b0, 4'hD, 32'h0000_0600, 8'd1, 3'd4, 2'b00, 16'h0,    128'h0,                                   0,   2'b00,    1'b0};
    vt[13] = '{1'b0, 4'hE, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 16'h0,    128'h0,                                   0,   2'b00,    1'b0};
    vt[14] = '{1'b1, 4'h0, 32'h0000_0000, 8'd0, 3'd4, 2'b01, 16'hFFFF, {16{8'h77}},                              0,   2'b00,    1'b0};
    vt[15] = '{1'b0, 4'h1, 32'h0001_0000, 8'd0, 3'd4, 2'b01, 16'h0,    128'h0,                                   0,   OOR_RESP, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bid", bid, 4'h0);
    chk("rst_rid", rid, 4'h0);
    chk("rst_rdata", rdata, 128'd0);
    rst_wr = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i]);
      end else begin
        push_model_read(vt[i]);
        issue_read(vt[i]);
        collect(vt[i].stall);
      end
    end

    // WRAP from the top of a 64-byte window: expected order written out by hand
    rq.push_back('{4'h2, 128'hA3, 2'b00, 1'b0});
    rq.push_back('{4'h2, 128'hA0, 2'b00, 1'b0});
    rq.push_back('{4'h2, 128'hA1, 2'b00, 1'b0});
    rq.push_back('{4'h2, 128'hA2, 2'b00, 1'b1});
    hv = '{1'b0, 4'h2, 32'h0000_0130, 8'd3, 3'd4, 2'b10, 16'h0, 128'h0, 0, 2'b00, 1'b0};
    issue_read(hv);
    collect(1'b0);

    // Stalled 4-beat read: C0, C1 from the truncated burst, B2, B3 from before it
    rq.push_back('{4'h3, 128'hC0, 2'b00, 1'b0});
    rq.push_back('{4'h3, 128'hC1, 2'b00, 1'b0});
    rq.push_back('{4'h3, 128'hB2, 2'b00, 1'b0});
    rq.push_back('{4'h3, 128'hB3, 2'b00, 1'b1});
    hv = '{1'b0, 4'h3, 32'h0000_0300, 8'd3, 3'd4, 2'b01, 16'h0, 128'h0, 0, 2'b00, 1'b1};
    issue_read(hv);
    collect(1'b1);

    // Reset in the middle of a write burst after one beat has landed
    @(negedge clk);
    awvalid = 1'b1; awid = 4'h9; awaddr = 32'h200; awlen = 8'd3; awsize = 3'd4; awburst = 2'b01;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid_wready", wready, 1'b1);
    wvalid = 1'b1; wdata = 128'h5555_0000; wstrb = 16'hFFFF; wlast = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    rst_wr = 1'b1;
    @(negedge clk);
    rst_wr = 1'b0;
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_wready", wready, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_rst_bvalid_late", bvalid, 1'b0);

    rq.push_back('{4'h4, 128'h5555_0000, 2'b00, 1'b1});
    hv = '{1'b0, 4'h4, 32'h0000_0200, 8'd0, 3'd4, 2'b01, 16'h0, 128'h0, 0, 2'b00, 1'b0};
    issue_read(hv);
    collect(1'b0);
    rq.push_back('{4'h5, 128'hA1, 2'b00, 1'b1});
    hv = '{1'b0, 4'h5, 32'h0000_0110, 8'd0, 3'd4, 2'b01, 16'h0, 128'h0, 0, 2'b00, 1'b0};
    issue_read(hv);
    collect(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
